// File: rtl/datapath.sv
// ----------------------------------------------------------------------------
// datapath -- 16-bit register-file / shifter / ALU datapath
//
// Purpose:
//   Eight-entry register file (instance REGFILE, registers R0..R7) feeding
//   operand registers A and B, a one-bit shifter on B, operand muxes, a
//   four-function ALU, result register C and Z/N/V status flags.
//
// Optional feature:
//   DATAPATH_OVF_EN  defined   -> V_out is the registered signed overflow flag.
//                    undefined -> V_out is tied to 0 (Z_out/N_out unaffected).
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-high reset (clears A, B, C, flags, R0..R7)
//   vsel[1:0]     writeback select: 00 mdata, 01 sximm8, 10 {8'b0,PC}, 11 C
//   mdata[15:0]   memory data writeback source
//   sximm8[15:0]  sign-extended 8-bit immediate writeback source
//   PC[7:0]       program counter writeback source (zero-extended)
//   sximm5[15:0]  sign-extended 5-bit immediate, B operand when bsel=1
//   writenum[2:0] register-file write index
//   readnum[2:0]  register-file read index
//   write         register-file write enable
//   loada, loadb  operand register load enables
//   shift[1:0]    00 pass, 01 LSL1, 10 LSR1, 11 ASR1
//   asel          1 forces Ain to zero
//   bsel          1 selects sximm5 instead of shifter output
//   ALUop[1:0]    00 add, 01 sub, 10 and, 11 not B
//   loadc, loads  result / status register load enables
//   datapath_out  contents of register C
//   Z_out, N_out, V_out  registered zero / negative / overflow flags
// ----------------------------------------------------------------------------

module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [2:0]  writenum,
    input  logic [2:0]  readnum,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);

    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

    // Registers are kept as individually named signals so that they can be
    // inspected as REGFILE.R0 .. REGFILE.R7 from outside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
            R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
        end else if (write) begin
            case (writenum)
                3'd0: R0 <= data_in;
                3'd1: R1 <= data_in;
                3'd2: R2 <= data_in;
                3'd3: R3 <= data_in;
                3'd4: R4 <= data_in;
                3'd5: R5 <= data_in;
                3'd6: R6 <= data_in;
                default: R7 <= data_in;
            endcase
        end
    end

    // Combinational read; a write in the same cycle shows up after the edge.
    always_comb begin
        case (readnum)
            3'd0: data_out = R0;
            3'd1: data_out = R1;
            3'd2: data_out = R2;
            3'd3: data_out = R3;
            3'd4: data_out = R4;
            3'd5: data_out = R5;
            3'd6: data_out = R6;
            default: data_out = R7;
        endcase
    end

endmodule

module datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  vsel,
    input  logic [15:0] mdata,
    input  logic [15:0] sximm8,
    input  logic [7:0]  PC,
    input  logic [15:0] sximm5,
    input  logic [2:0]  writenum,
    input  logic [2:0]  readnum,
    input  logic        write,
    input  logic        loada,
    input  logic        loadb,
    input  logic [1:0]  shift,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  ALUop,
    input  logic        loadc,
    input  logic        loads,
    output logic [15:0] datapath_out,
    output logic        Z_out,
    output logic        N_out,
    output logic        V_out
);

    logic [15:0] data_in, data_out;
    logic [15:0] reg_a, reg_b, reg_c;
    logic [15:0] shifted, ain, bin, alu_out;

    always_comb begin
        case (vsel)
            2'b00:   data_in = mdata;
            2'b01:   data_in = sximm8;
            2'b10:   data_in = {8'b0, PC};
            default: data_in = reg_c;
        endcase
    end

    regfile REGFILE (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .readnum  (readnum),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            if (loada) reg_a <= data_out;
            if (loadb) reg_b <= data_out;
        end
    end

    always_comb begin
        case (shift)
            2'b00:   shifted = reg_b;
            2'b01:   shifted = {reg_b[14:0], 1'b0};
            2'b10:   shifted = {1'b0, reg_b[15:1]};
            default: shifted = {reg_b[15], reg_b[15:1]};
        endcase
        ain = asel ? 16'd0 : reg_a;
        bin = bsel ? sximm5 : shifted;
        case (ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_c <= '0;
            Z_out <= 1'b0;
            N_out <= 1'b0;
        end else begin
            if (loadc) reg_c <= alu_out;
            if (loads) begin
                Z_out <= (alu_out == 16'd0);
                N_out <= alu_out[15];
            end
        end
    end

    assign datapath_out = reg_c;

`ifdef DATAPATH_OVF_EN
    logic ovf, v_reg;

    // Add overflows when like-signed operands give a differently signed
    // result; subtract when unlike-signed operands flip the sign of Ain.
    always_comb begin
        case (ALUop)
            2'b00:   ovf = (ain[15] == bin[15]) && (alu_out[15] != ain[15]);
            2'b01:   ovf = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
            default: ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      v_reg <= 1'b0;
        else if (loads) v_reg <= ovf;
    end

    assign V_out = v_reg;
`else
    assign V_out = 1'b0;
`endif

endmodule

// File: tb/tb_datapath.sv
// ----------------------------------------------------------------------------
// tb_datapath -- self-checking bench for datapath
//
// Runs the directed MOV/ADD/CMP/MVN/AND/shift/overflow sequences, then a
// randomized run, an asynchronous reset in the middle of activity, and more
// random traffic. A behavioural model with plain integer arithmetic predicts
// C, the flags and the register file after each clock.
// ----------------------------------------------------------------------------

module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  vsel;
    logic [15:0] mdata, sximm8, sximm5;
    logic [7:0]  PC;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_out;
    logic        Z_out, N_out, V_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_r [8];
    int unsigned m_a, m_b, m_c;
    int unsigned m_z, m_n, m_v;

    datapath dut (
        .clk(clk), .reset(reset), .vsel(vsel), .mdata(mdata), .sximm8(sximm8),
        .PC(PC), .sximm5(sximm5), .writenum(writenum), .readnum(readnum),
        .write(write), .loada(loada), .loadb(loadb), .shift(shift),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, want 0x%04h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] dut_reg(input int i);
        case (i)
            0: return dut.REGFILE.R0;
            1: return dut.REGFILE.R1;
            2: return dut.REGFILE.R2;
            3: return dut.REGFILE.R3;
            4: return dut.REGFILE.R4;
            5: return dut.REGFILE.R5;
            6: return dut.REGFILE.R6;
            default: return dut.REGFILE.R7;
        endcase
    endfunction

    function automatic int to_signed(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    task automatic clear_ctrl();
        vsel = 2'b00; mdata = 16'd0; sximm8 = 16'd0; PC = 8'd0; sximm5 = 16'd0;
        writenum = 3'd0; readnum = 3'd0; write = 1'b0; loada = 1'b0;
        loadb = 1'b0; shift = 2'b00; asel = 1'b0; bsel = 1'b0; ALUop = 2'b00;
        loadc = 1'b0; loads = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    endtask

    // Predict the effect of the current inputs, clock once and compare.
    task automatic applyStimulus();
        int unsigned wb, rd, bsh, ain, bin, res;
        int          sres;
        int unsigned ovf;
        case (vsel)
            2'b00: wb = mdata;
            2'b01: wb = sximm8;
            2'b10: wb = PC;
            default: wb = m_c;
        endcase
        rd = m_r[readnum];
        case (shift)
            2'b00: bsh = m_b;
            2'b01: bsh = (m_b * 2) % 65536;
            2'b10: bsh = m_b / 2;
            default: bsh = m_b / 2 + ((m_b >= 32768) ? 32768 : 0);
        endcase
        ain = asel ? 0 : m_a;
        bin = bsel ? int'(sximm5) : bsh;
        ovf = 0;
        case (ALUop)
            2'b00: begin
                sres = to_signed(ain) + to_signed(bin);
                res  = (ain + bin) % 65536;
                ovf  = (sres > 32767 || sres < -32768) ? 1 : 0;
            end
            2'b01: begin
                sres = to_signed(ain) - to_signed(bin);
                res  = (ain + 65536 - bin) % 65536;
                ovf  = (sres > 32767 || sres < -32768) ? 1 : 0;
            end
            2'b10: res = ain & bin;
            default: res = 65535 - bin;
        endcase
`ifndef DATAPATH_OVF_EN
        ovf = 0;
`endif
        @(posedge clk);
        #1;
        if (write) m_r[writenum] = wb;
        if (loada) m_a = rd;
        if (loadb) m_b = rd;
        if (loadc) m_c = res;
        if (loads) begin
            m_z = (res == 0) ? 1 : 0;
            m_n = (res >= 32768) ? 1 : 0;
            m_v = ovf;
        end
        checkOutput("datapath_out", datapath_out, 16'(m_c));
        checkOutput("Z_out", {15'd0, Z_out}, 16'(m_z));
        checkOutput("N_out", {15'd0, N_out}, 16'(m_n));
        checkOutput("V_out", {15'd0, V_out}, 16'(m_v));
        if (write) checkOutput("regfile_write", dut_reg(int'(writenum)), 16'(m_r[writenum]));
    endtask

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            vsel = 2'($urandom); mdata = 16'($urandom); sximm8 = 16'($urandom);
            PC = 8'($urandom); sximm5 = 16'($urandom);
            writenum = 3'($urandom); readnum = 3'($urandom);
            write = 1'($urandom); loada = 1'($urandom); loadb = 1'($urandom);
            shift = 2'($urandom); asel = 1'($urandom_range(0, 3) == 0);
            bsel = 1'($urandom_range(0, 3) == 0); ALUop = 2'($urandom);
            loadc = 1'($urandom); loads = 1'($urandom);
            applyStimulus();
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_out"}, datapath_out, 16'd0);
        checkOutput({tag, "_flags"}, {13'd0, Z_out, N_out, V_out}, 16'd0);
        for (int i = 0; i < 8; i++) checkOutput({tag, "_reg"}, dut_reg(i), 16'd0);
    endtask

    localparam logic [15:0] OVF_V =
`ifdef DATAPATH_OVF_EN
        16'd1;
`else
        16'd0;
`endif

    initial begin
        clear_ctrl();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_init");
        @(negedge clk) reset = 1'b0;

        // MOV R0,#1 then C = 0 + R0
        clear_ctrl(); sximm8 = 16'd1; vsel = 2'b01; write = 1'b1; writenum = 3'd0; applyStimulus();
        clear_ctrl(); readnum = 3'd0; loadb = 1'b1; applyStimulus();
        clear_ctrl(); asel = 1'b1; loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("mov_out", datapath_out, 16'h0001);
        checkOutput("mov_z", {15'd0, Z_out}, 16'd0);

        // ADD R2 = R1 + R0 with R1 = 8, then read R2 back through C
        clear_ctrl(); sximm8 = 16'd8; vsel = 2'b01; write = 1'b1; writenum = 3'd1; applyStimulus();
        clear_ctrl(); readnum = 3'd1; loada = 1'b1; applyStimulus();
        clear_ctrl(); loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("add_out", datapath_out, 16'h0009);
        clear_ctrl(); vsel = 2'b11; write = 1'b1; writenum = 3'd2; applyStimulus();
        clear_ctrl(); readnum = 3'd2; loadb = 1'b1; applyStimulus();
        clear_ctrl(); asel = 1'b1; loadc = 1'b1; applyStimulus();
        checkOutput("add_readback", datapath_out, 16'h0009);

        // CMP: A=8, B=1 shifted left -> 8-2
        clear_ctrl(); readnum = 3'd0; loadb = 1'b1; applyStimulus();
        clear_ctrl(); shift = 2'b01; ALUop = 2'b01; loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("cmp_out", datapath_out, 16'd6);
        checkOutput("cmp_flags", {13'd0, Z_out, N_out, V_out}, 16'd0);

        // MVN of 1 and of 0x8000
        clear_ctrl(); ALUop = 2'b11; loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("mvn_1", datapath_out, 16'hFFFE);
        clear_ctrl(); mdata = 16'h8000; write = 1'b1; writenum = 3'd3; applyStimulus();
        clear_ctrl(); readnum = 3'd3; loadb = 1'b1; applyStimulus();
        clear_ctrl(); ALUop = 2'b11; loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("mvn_8000", datapath_out, 16'h7FFF);
        checkOutput("mvn_z", {15'd0, Z_out}, 16'd0);

        // AND giving zero, then shifts of B=8, then C -> R6
        clear_ctrl(); readnum = 3'd0; loadb = 1'b1; applyStimulus();
        clear_ctrl(); ALUop = 2'b10; loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("and_out", datapath_out, 16'd0);
        checkOutput("and_z", {15'd0, Z_out}, 16'd1);
        clear_ctrl(); readnum = 3'd1; loadb = 1'b1; applyStimulus();
        clear_ctrl(); asel = 1'b1; shift = 2'b10; loadc = 1'b1; applyStimulus();
        checkOutput("lsr_out", datapath_out, 16'd4);
        clear_ctrl(); asel = 1'b1; shift = 2'b01; loadc = 1'b1; applyStimulus();
        checkOutput("lsl_out", datapath_out, 16'd16);
        clear_ctrl(); vsel = 2'b11; write = 1'b1; writenum = 3'd6; applyStimulus();
        checkOutput("r6_value", dut.REGFILE.R6, 16'd16);

        // Overflow: 0x7FFF + 1
        clear_ctrl(); mdata = 16'h7FFF; write = 1'b1; writenum = 3'd4; applyStimulus();
        clear_ctrl(); readnum = 3'd4; loada = 1'b1; applyStimulus();
        clear_ctrl(); readnum = 3'd0; loadb = 1'b1; applyStimulus();
        clear_ctrl(); loadc = 1'b1; loads = 1'b1; applyStimulus();
        checkOutput("ovf_out", datapath_out, 16'h8000);
        checkOutput("ovf_n", {15'd0, N_out}, 16'd1);
        checkOutput("ovf_v", {15'd0, V_out}, OVF_V);

        random_cycles(300);

        // Asynchronous reset between edges, with every enable asserted
        vsel = 2'b01; sximm8 = 16'h1234; write = 1'b1; loada = 1'b1; loadb = 1'b1;
        loadc = 1'b1; loads = 1'b1; ALUop = 2'b11;
        reset = 1'b1;
        #2 check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_held");
        @(negedge clk) reset = 1'b0;
        clear_ctrl();
        model_reset();

        random_cycles(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
